// File: rtl/operand_bus_arbiter_pkg.sv
// operand_bus_arbiter_pkg: sizes, FSM encodings and helpers shared by the operand bus, register file and ALU
package operand_bus_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_HOLD = 2'd2} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/operand_bus_arbiter_if.sv
// operand_bus_arbiter_if: requester handshake, mux select/return and ALU valid/ready channel
interface operand_bus_arbiter_if import operand_bus_arbiter_pkg::*; #(parameter int DATA_W = 8);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [SEL_W-1:0] sel;
  logic [DATA_W-1:0] mux_operand;
  logic [DATA_W-1:0] op_data;
  logic op_valid;
  logic op_ready;
  logic busy;
  modport master (input req, mux_operand, op_ready, output ack, sel, op_data, op_valid, busy);
  modport slave (output req, mux_operand, op_ready, input ack, sel, op_data, op_valid, busy);
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: picks the first unmasked request at or after ptr, wrapping modulo 4
module rr_pick4 import operand_bus_arbiter_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);
  logic [N_REQ-1:0] eff, rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    eff = req & ~mask;
    rot = N_REQ'({eff, eff} >> ptr);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    gnt_idx = ptr + off;
    any = |eff;
  end
endmodule

// File: rtl/operand_bus_arbiter.sv
// operand_bus_arbiter: round-robin share of the operand bus, captures the mux output and hands it to the ALU
module operand_bus_arbiter import operand_bus_arbiter_pkg::*; #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst_n,
  operand_bus_arbiter_if.master bus
);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_ptr, gnt_idx;
  logic [N_REQ-1:0] ack_n, pick_mask;
  logic [DATA_W-1:0] data_n;
  logic valid_n, any, accept;
  assign accept = state == ST_HOLD && bus.op_valid && bus.op_ready;
  // on accept the granted requester drops to lowest priority and is excluded from the same-edge re-arbitration
  assign pick_ptr = state == ST_HOLD ? bus.sel + SEL_W'(1) : ptr;
  assign pick_mask = state == ST_HOLD ? onehot(bus.sel) : '0;
  assign bus.busy = state != ST_IDLE;
  rr_pick4 u_pick (.req(bus.req), .mask(pick_mask), .ptr(pick_ptr), .gnt_idx(gnt_idx), .any(any));
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = bus.sel;
    ack_n = '0;
    data_n = bus.op_data;
    valid_n = bus.op_valid;
    case (state)
      ST_IDLE: begin
        sel_n = any ? gnt_idx : bus.sel;
        state_n = any ? ST_CAPTURE : ST_IDLE;
      end
      ST_CAPTURE: begin
        data_n = bus.mux_operand;
        valid_n = 1'b1;
        ack_n = onehot(bus.sel);
        state_n = ST_HOLD;
      end
      ST_HOLD: if (accept) begin
        ptr_n = pick_ptr;
        valid_n = 1'b0;
        sel_n = any ? gnt_idx : bus.sel;
        state_n = any ? ST_CAPTURE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      bus.sel <= '0;
      bus.ack <= '0;
      bus.op_data <= '0;
      bus.op_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      bus.sel <= sel_n;
      bus.ack <= ack_n;
      bus.op_data <= data_n;
      bus.op_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_operand_bus_arbiter.sv
// tb_operand_bus_arbiter: table vectors, directed corner sequences and a random run against a reference model
module tb_operand_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] r [4];
  int errors = 0;
  int checks = 0;
  operand_bus_arbiter_if bus ();
  operand_bus_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mux_operand = r[bus.sel];
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       valid;
    logic [7:0] data;
    logic       busy;
  } vec_t;
  vec_t tbl [10];

  int mphase, mptr;
  logic [1:0] msel;
  logic [7:0] mdata;
  logic mvalid;
  logic [3:0] mack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [1:0] sel, input logic [3:0] ack,
                            input logic valid, input logic [7:0] data, input logic busy);
    chk({nm, ".sel"}, 32'(bus.sel), 32'(sel));
    chk({nm, ".ack"}, 32'(bus.ack), 32'(ack));
    chk({nm, ".op_valid"}, 32'(bus.op_valid), 32'(valid));
    chk({nm, ".op_data"}, 32'(bus.op_data), 32'(data));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] mpick(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++)
      if (rq[(p + k) % 4]) return 2'((p + k) % 4);
    return 2'd0;
  endfunction

  // one clock of the arbiter described as: wait for a request, settle a cycle, present until taken
  task automatic model_step(input logic [3:0] rq, input logic rdy);
    logic [3:0] rest;
    mack = 4'h0;
    if (mphase == 0) begin
      if (rq != 4'h0) begin
        msel = mpick(rq, mptr);
        mphase = 1;
      end
    end else if (mphase == 1) begin
      mdata = r[msel];
      mvalid = 1'b1;
      mack = 4'(1) << msel;
      mphase = 2;
    end else if (rdy) begin
      mptr = (int'(msel) + 1) % 4;
      mvalid = 1'b0;
      rest = rq & ~(4'(1) << msel);
      if (rest != 4'h0) begin
        msel = mpick(rest, mptr);
        mphase = 1;
      end else mphase = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 4'hF;
    bus.op_ready = 1'b0;
    r[0] = 8'h10; r[1] = 8'h21; r[2] = 8'h32; r[3] = 8'h43;
    tbl[0] = '{4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 8'h10, 1'b1};
    tbl[2] = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b0, 8'h10, 1'b1};
    tbl[3] = '{4'hF, 1'b1, 2'd1, 4'h2, 1'b1, 8'h21, 1'b1};
    tbl[4] = '{4'hF, 1'b1, 2'd2, 4'h0, 1'b0, 8'h21, 1'b1};
    tbl[5] = '{4'hF, 1'b1, 2'd2, 4'h4, 1'b1, 8'h32, 1'b1};
    tbl[6] = '{4'hF, 1'b1, 2'd3, 4'h0, 1'b0, 8'h32, 1'b1};
    tbl[7] = '{4'hF, 1'b1, 2'd3, 4'h8, 1'b1, 8'h43, 1'b1};
    tbl[8] = '{4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 8'h43, 1'b1};
    tbl[9] = '{4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 8'h10, 1'b1};

    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset_hold", 2'd0, 4'h0, 1'b0, 8'h00, 1'b0);
    end
    rst_n = 1'b1;
    bus.req = 4'h0;
    tick();

    r[2] = 8'hA5;
    bus.req = 4'b0100;
    bus.op_ready = 1'b1;
    tick();
    expect_out("single_sel", 2'd2, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    expect_out("single_cap", 2'd2, 4'b0100, 1'b1, 8'hA5, 1'b1);
    bus.req = 4'h0;
    tick();
    expect_out("single_done", 2'd2, 4'h0, 1'b0, 8'hA5, 1'b0);
    bus.req = 4'hF;
    bus.op_ready = 1'b0;
    tick();
    expect_out("ptr_after_single", 2'd3, 4'h0, 1'b0, 8'hA5, 1'b1);
    r[2] = 8'h32;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req = tbl[i].req;
      bus.op_ready = tbl[i].rdy;
      tick();
      expect_out($sformatf("fair[%0d]", i), tbl[i].sel, tbl[i].ack, tbl[i].valid, tbl[i].data, tbl[i].busy);
    end

    bus.req = 4'h0;
    do_reset();
    bus.req = 4'b0010;
    bus.op_ready = 1'b0;
    tick();
    expect_out("bp_sel", 2'd1, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    expect_out("bp_cap", 2'd1, 4'b0010, 1'b1, 8'h21, 1'b1);
    bus.req = 4'h0;
    r[1] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("bp_hold", 2'd1, 4'h0, 1'b1, 8'h21, 1'b1);
    end
    bus.op_ready = 1'b1;
    tick();
    expect_out("bp_accept", 2'd1, 4'h0, 1'b0, 8'h21, 1'b0);

    bus.req = 4'b1000;
    bus.op_ready = 1'b0;
    tick();
    expect_out("wd_sel", 2'd3, 4'h0, 1'b0, 8'h21, 1'b1);
    bus.req = 4'h0;
    tick();
    expect_out("wd_cap", 2'd3, 4'b1000, 1'b1, 8'h43, 1'b1);
    bus.op_ready = 1'b1;
    tick();
    expect_out("wd_accept", 2'd3, 4'h0, 1'b0, 8'h43, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stray_ready", 2'd3, 4'h0, 1'b0, 8'h43, 1'b0);
    end

    bus.req = 4'b0010;
    tick();
    tick();
    expect_out("pre_rst_cap", 2'd1, 4'b0010, 1'b1, 8'hFF, 1'b1);
    bus.req = 4'h0;
    tick();
    bus.req = 4'b0100;
    bus.op_ready = 1'b0;
    tick();
    tick();
    expect_out("pre_rst_hold", 2'd2, 4'b0100, 1'b1, 8'h32, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 2'd0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1001;
    tick();
    expect_out("post_rst_sel", 2'd0, 4'h0, 1'b0, 8'h00, 1'b1);
    tick();
    expect_out("post_rst_cap", 2'd0, 4'b0001, 1'b1, 8'h10, 1'b1);

    bus.req = 4'h0;
    do_reset();
    mphase = 0; mptr = 0; msel = 2'd0; mdata = 8'h00; mvalid = 1'b0; mack = 4'h0;
    for (int i = 0; i < 400; i++) begin
      bus.req = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom);
      bus.op_ready = ($urandom % 3) != 0;
      for (int j = 0; j < 4; j++)
        if ($urandom % 4 == 0) r[j] = 8'($urandom);
      @(posedge clk);
      model_step(bus.req, bus.op_ready);
      #1;
      expect_out("random", msel, mack, mvalid, mdata, mphase != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
